// File: rtl/lights_out_game_ctrl.sv
// Game sequencer for the 3x3 lights-out field: clear/scramble, press decoding, move count, win detect.
// Define MOVE_LIMIT_EN to enable the move budget (MAX_MOVES) and the LOST state.
module lights_out_game_ctrl #(
    parameter int unsigned SCRAMBLE_MOVES = 7,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter logic [7:0]  MAX_MOVES      = 8'd40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [8:0] btn,
    input  logic       start,
    input  logic [8:0] field,
    output logic       cmd_valid,
    output logic [8:0] cmd_onehot,
    output logic       cmd_clear,
    output logic [7:0] move_count,
    output logic       busy,
    output logic       won,
    output logic       lost
);

    typedef enum logic [3:0] {
        IDLE, CLEAR, SCRAMBLE, SSETTLE, PLAY, WAIT, PSETTLE, WIN
`ifdef MOVE_LIMIT_EN
        , LOST
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [8:0]  btn_q;
    logic [3:0]  scr_cnt_q, scr_cnt_d;
    logic [7:0]  mc_q, mc_d;
    logic [8:0]  cmd_q, cmd_d;

    logic [3:0]  scr_raw, scr_idx;
    logic [8:0]  scr_onehot;
    logic [8:0]  press;
    logic        press_ok;

    // Right-shifting Galois LFSR for x^16+x^14+x^13+x^11.
    assign lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign scr_raw    = lfsr_q[3:0];
    assign scr_idx    = (scr_raw < 4'd9) ? scr_raw : scr_raw - 4'd9;
    assign scr_onehot = 9'b1 << scr_idx;

    // Only a single fresh rising edge is a legal move; chords are dropped.
    assign press    = btn & ~btn_q;
    assign press_ok = (press != 9'd0) && ((press & (press - 9'd1)) == 9'd0);

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_d   = state_q;
        scr_cnt_d = scr_cnt_q;
        mc_d      = mc_q;
        cmd_d     = cmd_q;
        case (state_q)
            IDLE:     if (start) state_d = CLEAR;
            CLEAR: begin
                mc_d      = 8'd0;
                scr_cnt_d = 4'(SCRAMBLE_MOVES);
                state_d   = SCRAMBLE;
            end
            SCRAMBLE: begin
                scr_cnt_d = scr_cnt_q - 4'd1;
                if (scr_cnt_q == 4'd1) state_d = SSETTLE;
            end
            SSETTLE:  state_d = (field == 9'd0) ? CLEAR : PLAY;
            PLAY: begin
                if (press_ok) begin
                    cmd_d   = press;
                    mc_d    = (mc_q == 8'hFF) ? mc_q : mc_q + 8'd1;
                    state_d = WAIT;
                end else if (start) begin
                    state_d = CLEAR;
                end
            end
            WAIT:     state_d = PSETTLE;
            PSETTLE: begin
                if (field == 9'd0)           state_d = WIN;
`ifdef MOVE_LIMIT_EN
                else if (mc_q == MAX_MOVES)  state_d = LOST;
`endif
                else                         state_d = PLAY;
            end
            WIN:      if (start) state_d = CLEAR;
`ifdef MOVE_LIMIT_EN
            LOST:     if (start) state_d = CLEAR;
`endif
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state_q   <= IDLE;
            lfsr_q    <= LFSR_SEED;
            btn_q     <= 9'd0;
            scr_cnt_q <= 4'd0;
            mc_q      <= 8'd0;
            cmd_q     <= 9'd0;
        end else if (ena) begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            btn_q     <= btn;
            scr_cnt_q <= scr_cnt_d;
            mc_q      <= mc_d;
            cmd_q     <= cmd_d;
        end
    end

    // Strobes are gated by ena so a frozen controller never re-issues a command.
    always_comb begin
        cmd_valid  = 1'b0;
        cmd_clear  = 1'b0;
        cmd_onehot = 9'd0;
        if (ena) begin
            case (state_q)
                CLEAR:    cmd_clear = 1'b1;
                SCRAMBLE: begin
                    cmd_valid  = 1'b1;
                    cmd_onehot = scr_onehot;
                end
                WAIT: begin
                    cmd_valid  = 1'b1;
                    cmd_onehot = cmd_q;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state_q == CLEAR) || (state_q == SCRAMBLE) || (state_q == SSETTLE);
    assign won        = (state_q == WIN);
    assign move_count = mc_q;

`ifdef MOVE_LIMIT_EN
    assign lost = (state_q == LOST);
`else
    // Without the move budget MAX_MOVES has no effect and play is unlimited.
    assign lost = 1'b0 & (|MAX_MOVES);
`endif

endmodule
